// File: rtl/key_schedule_seq.sv
// ---------------------------------------------------------------------------
// key_schedule_seq
//
// Iterative PRESENT-80 key schedule generator. A cipher key is accepted in
// IDLE and the 80-bit key-register state for every round (K1..K(ROUNDS+1)) is
// then streamed over a valid/ready handshake. The round key for the datapath
// is rk[79:16]. One key update happens per accepted transfer. rk_ready only
// feeds register enables, so there is no combinational path from rk_ready to
// rk.
//
// Optional feature (compile-time macro KEY_SCHEDULE_RESTART_EN):
//   defined   - ack stays high in RUN as well; a req in RUN reloads the key
//               and restarts the stream at K1, taking priority over a
//               simultaneous transfer.
//   undefined - ack is high only in IDLE; req in RUN has no effect.
//
// Parameters:
//   ROUNDS    number of key updates (1..31); ROUNDS+1 keys are emitted.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   req       start request, key sampled when req && ack
//   key       80-bit cipher key
//   ack       key can be accepted this cycle
//   rk        current key-register state (round key is rk[79:16])
//   rk_idx    index of rk, 1..ROUNDS+1
//   rk_valid  rk / rk_idx valid
//   rk_ready  consumer accepts rk this cycle
//   rk_last   high with rk_valid when rk_idx == ROUNDS+1
//   busy      high while streaming
// ---------------------------------------------------------------------------
module key_schedule_seq #(
    parameter int ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [79:0] key,
    output logic        ack,
    output logic [79:0] rk,
    output logic [5:0]  rk_idx,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic        rk_last,
    output logic        busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS + 1);

`ifdef KEY_SCHEDULE_RESTART_EN
    localparam logic ACK_IN_RUN = 1'b1;
`else
    localparam logic ACK_IN_RUN = 1'b0;
`endif

    state_t      state_r;
    logic [79:0] rk_r;
    logic [5:0]  idx_r;
    logic        valid_r;
    logic        last_r;
    logic        busy_r;
    logic        ack_r;

    // PRESENT 4-bit S-box
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'hC;
            4'h1:    y = 4'h5;
            4'h2:    y = 4'h6;
            4'h3:    y = 4'hB;
            4'h4:    y = 4'h9;
            4'h5:    y = 4'h0;
            4'h6:    y = 4'hA;
            4'h7:    y = 4'hD;
            4'h8:    y = 4'h3;
            4'h9:    y = 4'hE;
            4'hA:    y = 4'hF;
            4'hB:    y = 4'h8;
            4'hC:    y = 4'h4;
            4'hD:    y = 4'h7;
            4'hE:    y = 4'h1;
            4'hF:    y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // One PRESENT-80 key-register update: rotate left by 61, S-box on the
    // top nibble, XOR the 5-bit round counter into bits [19:15].
    function automatic logic [79:0] key_update(input logic [79:0] s,
                                               input logic [4:0]  i);
        logic [79:0] t;
        t          = {s[18:0], s[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ i;
        return t;
    endfunction

    // Control FSM and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            rk_r    <= 80'd0;
            idx_r   <= 6'd0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            ack_r   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req) begin
                        state_r <= RUN;
                        rk_r    <= key;
                        idx_r   <= 6'd1;
                        valid_r <= 1'b1;
                        last_r  <= (LAST_IDX == 6'd1);
                        busy_r  <= 1'b1;
                        ack_r   <= ACK_IN_RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
`ifdef KEY_SCHEDULE_RESTART_EN
                    // A reload wins over a transfer in the same cycle; the
                    // transferred key is simply considered consumed.
                    if (req) begin
                        rk_r    <= key;
                        idx_r   <= 6'd1;
                        last_r  <= (LAST_IDX == 6'd1);
                    end else
`endif
                    if (rk_ready) begin
                        if (last_r) begin
                            // rk keeps the final key after the stream ends
                            state_r <= IDLE;
                            idx_r   <= 6'd0;
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            busy_r  <= 1'b0;
                            ack_r   <= 1'b1;
                        end else begin
                            rk_r   <= key_update(rk_r, idx_r[4:0]);
                            idx_r  <= idx_r + 6'd1;
                            last_r <= ((idx_r + 6'd1) == LAST_IDX);
                        end
                    end else begin
                        // backpressure: everything holds
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= 6'd0;
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    ack_r   <= 1'b1;
                end
            endcase
        end
    end

    assign ack      = ack_r;
    assign rk       = rk_r;
    assign rk_idx   = idx_r;
    assign rk_valid = valid_r;
    assign rk_last  = last_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_key_schedule_seq.sv
module tb_key_schedule_seq;

    localparam int ROUNDS = 31;

    typedef struct packed {
        logic [79:0] rk;
        logic [5:0]  idx;
        logic        last;
    } xfer_t;

    logic        clk;
    logic        rst;
    logic        req;
    logic [79:0] key;
    logic        ack;
    logic [79:0] rk;
    logic [5:0]  rk_idx;
    logic        rk_valid;
    logic        rk_ready;
    logic        rk_last;
    logic        busy;

    logic        req1;
    logic [79:0] key1;
    logic        ack1;
    logic [79:0] rk1;
    logic [5:0]  rk_idx1;
    logic        rk_valid1;
    logic        rk_ready1;
    logic        rk_last1;
    logic        busy1;

    int n_checks;
    int n_fail;

    xfer_t exp_q[$];
    xfer_t obs_q[$];

    key_schedule_seq #(.ROUNDS(ROUNDS)) u_dut (
        .clk(clk), .rst(rst), .req(req), .key(key), .ack(ack),
        .rk(rk), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk_last(rk_last), .busy(busy)
    );

    key_schedule_seq #(.ROUNDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .key(key1), .ack(ack1),
        .rk(rk1), .rk_idx(rk_idx1), .rk_valid(rk_valid1), .rk_ready(rk_ready1),
        .rk_last(rk_last1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference key update written from the algorithm definition
    function automatic logic [79:0] m_update(input logic [79:0] s, input int i);
        logic [63:0] sb;
        logic [79:0] t;
        logic [79:0] ix;
        sb = 64'h21748FE3DA09B65C;
        t  = (s << 61) | (s >> 19);
        t[79:76] = sb[t[79:76]*4 +: 4];
        ix = 80'(i & 31);
        t  = t ^ (ix << 15);
        return t;
    endfunction

    task automatic push_stream(input logic [79:0] k, input int from_i, input int to_i);
        logic [79:0] s;
        s = k;
        for (int i = 1; i <= ROUNDS + 1; i++) begin
            if (i >= from_i && i <= to_i)
                exp_q.push_back({s, 6'(i), (i == ROUNDS + 1)});
            s = m_update(s, i);
        end
    endtask

    // Called at a negedge with the DUT idle: one-cycle request pulse
    task automatic start(input logic [79:0] k);
        key = k;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    // Consume the stream with rk_ready=1, recording every transfer; optionally
    // raise req for one cycle when rk_idx first equals inj_idx.
    task automatic collect(input int inj_idx, input logic [79:0] inj_key, input int max_cycles);
        int cyc;
        bit seen;
        bit injected;
        bit done;
        cyc = 0; seen = 1'b0; injected = 1'b0; done = 1'b0;
        rk_ready = 1'b1;
        while (!done && cyc < max_cycles) begin
            req = 1'b0;
            if (rk_valid) begin
                seen = 1'b1;
                obs_q.push_back({rk, rk_idx, rk_last});
                if (!injected && rk_idx == 6'(inj_idx)) begin
                    key = inj_key;
                    req = 1'b1;
                    injected = 1'b1;
                end
            end else if (seen) begin
                done = 1'b1;
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        req = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL collect_timeout: stream still running after %0d cycles", max_cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; key = 80'd0; rk_ready = 1'b0;
        req1 = 1'b0; key1 = 80'd0; rk_ready1 = 1'b0;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({ack, rk_valid, rk_last, busy, rk_idx, rk} !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 80'd0}) begin
            n_fail++;
            $display("FAIL reset_state: ack=%b valid=%b last=%b busy=%b idx=%0d rk=%h, expected 1 0 0 0 0 0",
                     ack, rk_valid, rk_last, busy, rk_idx, rk);
        end
        n_checks++;
        if ({ack1, rk_valid1, busy1, rk_idx1} !== {1'b1, 1'b0, 1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL reset_state_r1: ack=%b valid=%b busy=%b idx=%0d", ack1, rk_valid1, busy1, rk_idx1);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_stream();
        xfer_t e, o;
        int n;
        push_stream(80'd0, 1, ROUNDS + 1);
        start(80'd0);
        n_checks++;
        if ({rk, rk_idx, rk_valid, busy, ack} !== {80'd0, 6'd1, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_k1_latency: rk=%h idx=%0d valid=%b busy=%b ack=%b, expected 0 1 1 1 0",
                     rk, rk_idx, rk_valid, busy, ack);
        end
        collect(-1, 80'd0, 200);
        n = obs_q.size();
        n_checks++;
        if (n !== ROUNDS + 1) begin
            n_fail++;
            $display("FAIL zero_count: %0d valid cycles, expected %0d", n, ROUNDS + 1);
        end
        if (n >= 2) begin
            o = obs_q[1];
            n_checks++;
            if ({o.rk, o.idx} !== {80'hC0000000000000008000, 6'd2}) begin
                n_fail++;
                $display("FAIL zero_k2: rk=%h idx=%0d, expected c0000000000000008000 2", o.rk, o.idx);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL zero_stream: rk=%h idx=%0d last=%b, expected rk=%h idx=%0d last=%b",
                         o.rk, o.idx, o.last, e.rk, e.idx, e.last);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_checks++;
        if ({rk_valid, ack, busy, rk_last, rk_idx} !== {1'b0, 1'b1, 1'b0, 1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL zero_end_idle: valid=%b ack=%b busy=%b last=%b idx=%0d, expected 0 1 0 0 0",
                     rk_valid, ack, busy, rk_last, rk_idx);
        end
    endtask

    task automatic test_backpressure();
        logic [79:0] k3;
        k3 = m_update(m_update(80'd0, 1), 2);
        start(80'd0);
        rk_ready = 1'b1;
        @(negedge clk);
        rk_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({rk, rk_idx, rk_valid, rk_last} !== {80'hC0000000000000008000, 6'd2, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL backpressure_hold: cycle %0d rk=%h idx=%0d valid=%b last=%b, expected c0000000000000008000 2 1 0",
                         c, rk, rk_idx, rk_valid, rk_last);
            end
        end
        rk_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rk, rk_idx} !== {k3, 6'd3}) begin
            n_fail++;
            $display("FAIL backpressure_release: rk=%h idx=%0d, expected %h 3", rk, rk_idx, k3);
        end
        collect(-1, 80'd0, 200);
        obs_q.delete();
    endtask

    task automatic test_known_answer();
        xfer_t e, o;
        logic [79:0] ks [ROUNDS + 1];
        logic [63:0] sb, st, nx;
        sb = 64'h21748FE3DA09B65C;
        for (int i = 0; i <= ROUNDS; i++) ks[i] = 80'd0;
        push_stream({80{1'b1}}, 1, ROUNDS + 1);
        start({80{1'b1}});
        collect(-1, 80'd0, 200);
        for (int i = 0; i < obs_q.size() && i <= ROUNDS; i++) ks[i] = obs_q[i].rk;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL kat_stream: rk=%h idx=%0d last=%b, expected rk=%h idx=%0d last=%b",
                         o.rk, o.idx, o.last, e.rk, e.idx, e.last);
            end
        end
        n_checks++;
        if (exp_q.size() !== obs_q.size()) begin
            n_fail++;
            $display("FAIL kat_count: %0d leftover observed, %0d leftover expected", obs_q.size(), exp_q.size());
        end
        exp_q.delete(); obs_q.delete();
        st = 64'hFFFFFFFFFFFFFFFF;
        for (int r = 0; r < ROUNDS; r++) begin
            st = st ^ ks[r][79:16];
            for (int n = 0; n < 16; n++) nx[4*n +: 4] = sb[st[4*n +: 4]*4 +: 4];
            st = nx;
            for (int b = 0; b < 63; b++) nx[(16 * b) % 63] = st[b];
            nx[63] = st[63];
            st = nx;
        end
        st = st ^ ks[ROUNDS][79:16];
        n_checks++;
        if (st !== 64'h3333DCD3213210D2) begin
            n_fail++;
            $display("FAIL kat_cipher: ciphertext %h, expected 3333dcd3213210d2", st);
        end
    endtask

    task automatic test_async_reset();
        int c;
        start(80'h0123456789ABCDEF0123);
        rk_ready = 1'b1;
        c = 0;
        while (!(rk_valid && rk_idx == 6'd10) && c < 40) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (c >= 40) begin
            n_fail++;
            $display("FAIL async_reach_idx10: idx=%0d, expected 10", rk_idx);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({rk_valid, busy, rk, ack, rk_idx} !== {1'b0, 1'b0, 80'd0, 1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL async_reset_drop: valid=%b busy=%b rk=%h ack=%b idx=%0d, expected 0 0 0 1 0",
                     rk_valid, busy, rk, ack, rk_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({rk_valid, ack, busy} !== {1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL async_after_release: valid=%b ack=%b busy=%b, expected 0 1 0", rk_valid, ack, busy);
            end
        end
    endtask

    task automatic test_req_in_run();
        xfer_t e, o;
        logic [79:0] k1, k2;
        k1 = 80'hA5A5A5A5A5A5A5A5A5A5;
        k2 = 80'h13579BDF02468ACE1357;
`ifdef KEY_SCHEDULE_RESTART_EN
        push_stream(k1, 1, 5);
        push_stream(k2, 1, ROUNDS + 1);
`else
        push_stream(k1, 1, ROUNDS + 1);
`endif
        start(k1);
        collect(5, k2, 300);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL req_in_run_count: %0d transfers, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL req_in_run: rk=%h idx=%0d last=%b, expected rk=%h idx=%0d last=%b",
                         o.rk, o.idx, o.last, e.rk, e.idx, e.last);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_req_on_last_and_back_to_back();
        xfer_t e, o;
        logic [79:0] k1, k2, k3, kf;
        k1 = 80'hFEDCBA9876543210FEDC;
        k2 = 80'h00000000000000000001;
        k3 = 80'h8000000000000000000F;
        kf = k1;
        for (int i = 1; i <= ROUNDS; i++) kf = m_update(kf, i);
        push_stream(k1, 1, ROUNDS + 1);
`ifdef KEY_SCHEDULE_RESTART_EN
        push_stream(k2, 1, ROUNDS + 1);
`endif
        start(k1);
        collect(ROUNDS + 1, k2, 300);
`ifndef KEY_SCHEDULE_RESTART_EN
        n_checks++;
        if ({rk_valid, ack, rk} !== {1'b0, 1'b1, kf}) begin
            n_fail++;
            $display("FAIL last_req_ignored: valid=%b ack=%b rk=%h, expected 0 1 %h", rk_valid, ack, rk, kf);
        end
`endif
        // new request in the very cycle after the stream ends
        push_stream(k3, 1, ROUNDS + 1);
        start(k3);
        n_checks++;
        if ({rk, rk_idx, rk_valid} !== {k3, 6'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL back_to_back_k1: rk=%h idx=%0d valid=%b, expected %h 1 1", rk, rk_idx, rk_valid, k3);
        end
        collect(-1, 80'd0, 200);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL back_to_back_count: %0d transfers, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL back_to_back: rk=%h idx=%0d last=%b, expected rk=%h idx=%0d last=%b",
                         o.rk, o.idx, o.last, e.rk, e.idx, e.last);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_rounds1();
        key1 = 80'd0;
        rk_ready1 = 1'b1;
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        n_checks++;
        if ({rk1, rk_idx1, rk_valid1, rk_last1} !== {80'd0, 6'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL r1_key1: rk=%h idx=%0d valid=%b last=%b, expected 0 1 1 0", rk1, rk_idx1, rk_valid1, rk_last1);
        end
        @(negedge clk);
        n_checks++;
        if ({rk1, rk_idx1, rk_valid1, rk_last1} !== {80'hC0000000000000008000, 6'd2, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL r1_key2: rk=%h idx=%0d valid=%b last=%b, expected c0000000000000008000 2 1 1",
                     rk1, rk_idx1, rk_valid1, rk_last1);
        end
        @(negedge clk);
        n_checks++;
        if ({rk_valid1, rk_last1, ack1, busy1} !== {1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL r1_idle: valid=%b last=%b ack=%b busy=%b, expected 0 0 1 0", rk_valid1, rk_last1, ack1, busy1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_zero_stream();
        test_backpressure();
        test_known_answer();
        test_async_reset();
        test_req_in_run();
        test_req_on_last_and_back_to_back();
        test_rounds1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_schedule_seq.md
Name: key_schedule_seq

Overview:
- Iterative PRESENT-80 key schedule generator, directly upstream of the round datapath.
- Accepts an 80-bit cipher key, then streams the 80-bit key-register state for each round (K1..K(ROUNDS+1)) over a valid/ready handshake.
- The round datapath consumes each state on its k input; its key addition uses bits [79:16] as the 64-bit round key.
- One key update per accepted transfer; no combinational path from rk_ready to rk.

Parameters:
- ROUNDS, 31, number of key updates. Emits ROUNDS+1 keys. Legal range 1..31, limited by the 5-bit counter XOR field.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  1  start request; key sampled when req && ack.
- key  input  80  cipher key.
- ack  output  1  high in IDLE: key can be accepted this cycle.
- rk  output  80  current key-register state; the round key is rk[79:16].
- rk_idx  output  6  index of rk, 1..ROUNDS+1.
- rk_valid  output  1  rk and rk_idx are valid.
- rk_ready  input  1  consumer accepts rk this cycle.
- rk_last  output  1  high with rk_valid when rk_idx == ROUNDS+1.
- busy  output  1  high in RUN.

Behaviour:
- States: IDLE and RUN. The FSM is encoded in registers; all outputs are registered or decoded from state.
- Reset (async, rst=1): state=IDLE, rk=0, rk_idx=0, rk_valid=0, rk_last=0, busy=0, ack=1.
- IDLE:
  - ack=1, rk_valid=0.
  - On req=1 at a rising edge: rk<=key, rk_idx<=1, state<=RUN.
  - rk_valid=1 from the next cycle, so key-to-K1 latency is 1 cycle.
- RUN:
  - ack=0, busy=1, rk_valid=1.
  - rk, rk_idx and rk_last are held stable while rk_ready=0; this is mandatory, with no change under backpressure.
- Transfer (rk_valid && rk_ready) with rk_idx < ROUNDS+1:
  - rk <= update(rk, rk_idx[4:0]); rk_idx <= rk_idx+1.
  - One key per cycle is sustained when rk_ready is held high.
- update(s, i):
  - t = s rotated left by 61 bits, i.e. t = {s[18:0], s[79:19]}.
  - t[79:76] = S(t[79:76]), with the PRESENT S-box C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  - t[19:15] ^= i.
  - Result is t.
- Transfer with rk_idx == ROUNDS+1 (rk_last=1):
  - state<=IDLE, rk_valid<=0, rk_last<=0, rk_idx<=0.
  - rk retains the final value.
  - A new req may be accepted in the cycle after.
- Simultaneous events:
  - req in RUN is ignored unless the optional feature is enabled.
  - req in the same cycle as the final transfer is ignored, because ack=0 in that cycle.
- Reset mid-operation: returns to IDLE immediately and asynchronously; the partial stream is discarded; no further rk_valid.
- rk_ready while rk_valid=0: ignored.
- Counter width: rk_idx is 6 bits; only bits [4:0] enter the XOR. With ROUNDS<=31 the XOR index never exceeds 31.

Optional Feature:
- Macro: KEY_SCHEDULE_RESTART_EN.
- Defined:
  - ack is high in both IDLE and RUN.
  - req in RUN reloads rk<=key and rk_idx<=1 and stays in RUN. This takes priority over a simultaneous transfer; the transferred key counts as consumed, and the next output is the new K1.
  - Used to abort a stream when a new key arrives.
- Undefined: ack is high only in IDLE; req in RUN has no effect.

Test Plan:
- Zero key, rk_ready=1:
  - Cycle after req: rk=0, rk_idx=1.
  - Next cycle: rk=0xC0000000000000008000, rk_idx=2.
  - Exactly 32 valid cycles; rk_last only at rk_idx=32; then rk_valid=0, ack=1.
- Backpressure:
  - Zero key, rk_ready low for 5 cycles at rk_idx=2.
  - rk stays 0xC0000000000000008000, rk_idx stays 2, rk_valid stays 1.
  - After rk_ready rises, rk_idx=3 on the following cycle.
- Known answer: key=0xFFFFFFFFFFFFFFFFFFFF; stream all 32 keys into 31 round instances plus the final key addition, with plaintext 0xFFFFFFFFFFFFFFFF -> ciphertext 0x3333DCD3213210D2.
- Async reset: assert rst at rk_idx=10, mid-clock -> rk_valid, busy and rk drop to 0 without waiting for a clock edge; after release, ack=1 and no rk_valid until a new req.
- req in RUN:
  - Macro undefined: the stream continues unchanged to rk_idx=32.
  - Macro defined: the next cycle shows rk=new key, rk_idx=1.
- ROUNDS=1 build: exactly 2 keys emitted (idx 1 and 2), rk_last on idx 2, then IDLE.
